// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// FSM states, opcode/funct constants and ULA operation codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_if.sv
// Bus between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_if #(
  parameter int OP_W  = 6,
  parameter int ULA_W = 3,
  parameter int CNT_W = 16
);

  logic [OP_W-1:0]  OP;
  logic [OP_W-1:0]  Funct;
  logic             Zero;
  logic             MemReady;
  logic             IorD;
  logic             IRWrite;
  logic             MemWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ULASrcA;
  logic             Branch;
  logic             PCWrite;
  logic [1:0]       ULASrcB;
  logic [1:0]       PCSrc;
  logic [ULA_W-1:0] ULAControl;
  logic             Illegal;
  logic [CNT_W-1:0] Retired;
  logic [3:0]       State;

  modport master (
    input  OP, Funct, Zero, MemReady,
    output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ULASrcA, Branch,
           PCWrite, ULASrcB, PCSrc, ULAControl, Illegal, Retired, State
  );

  modport slave (
    output OP, Funct, Zero, MemReady,
    input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ULASrcA, Branch,
           PCWrite, ULASrcB, PCSrc, ULAControl, Illegal, Retired, State
  );

endinterface

// File: rtl/ula_decoder.sv
// Combinational R-type funct to ULA operation decoder; valid is low for
// any funct the ULA does not implement.
module ula_decoder
  import mips_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int ULA_W = 3
) (
  input  logic [OP_W-1:0]  funct,
  output logic [ULA_W-1:0] ulaControl,
  output logic             valid
);

  always_comb begin
    ulaControl = '0;
    valid      = 1'b1;
    case (funct)
      OP_W'(FUNCT_ADD): ulaControl = ULA_W'(ULA_ADD);
      OP_W'(FUNCT_SUB): ulaControl = ULA_W'(ULA_SUB);
      OP_W'(FUNCT_AND): ulaControl = ULA_W'(ULA_AND);
      OP_W'(FUNCT_OR):  ulaControl = ULA_W'(ULA_OR);
      OP_W'(FUNCT_SLT): ulaControl = ULA_W'(ULA_SLT);
      default:          valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM driving the datapath selects,
// plus a retired-instruction counter and an illegal-instruction pulse.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter int ULA_W         = 3,
  parameter int CNT_W         = 16,
  parameter int USE_MEM_READY = 1
) (
  input logic                clk,
  input logic                rst,
  multicycle_control_if.master bus
);

  state_t           state, nextState;
  logic [ULA_W-1:0] heldUla, decUla;
  logic             functValid, memReady, retireNow;
  logic [CNT_W-1:0] retired;

  logic             iorD, irWrite, memWrite, regDst, memtoReg, regWrite;
  logic             ulaSrcA, branch, pcWrite, illegal;
  logic [1:0]       ulaSrcB, pcSrc;
  logic [ULA_W-1:0] ulaControl;

  // The branch decision is taken in the datapath, so Zero is only observed.
  logic unusedZero;
  assign unusedZero = bus.Zero;

  assign memReady = (USE_MEM_READY != 0) ? bus.MemReady : 1'b1;

  ula_decoder #(
    .OP_W (OP_W),
    .ULA_W(ULA_W)
  ) u_ula_decoder (
    .funct     (bus.Funct),
    .ulaControl(decUla),
    .valid     (functValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= nextState;
  end

  // ALUWB replays the operation chosen in EXECUTE, even if Funct moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   heldUla <= '0;
    else if (state == EXECUTE) heldUla <= decUla;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            retired <= '0;
    else if (retireNow) retired <= retired + CNT_W'(1);
  end

  always_comb begin
    nextState  = state;
    retireNow  = 1'b0;
    iorD       = 1'b0;
    irWrite    = 1'b0;
    memWrite   = 1'b0;
    regDst     = 1'b0;
    memtoReg   = 1'b0;
    regWrite   = 1'b0;
    ulaSrcA    = 1'b0;
    branch     = 1'b0;
    pcWrite    = 1'b0;
    illegal    = 1'b0;
    ulaSrcB    = 2'b00;
    pcSrc      = 2'b00;
    ulaControl = '0;
    unique case (state)
      FETCH: begin
        ulaSrcB    = 2'b01;
        ulaControl = ULA_W'(ULA_ADD);
        if (memReady) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        ulaSrcB    = 2'b11;
        ulaControl = ULA_W'(ULA_ADD);
        case (bus.OP)
          OP_W'(OP_LW), OP_W'(OP_SW): nextState = MEMADR;
          OP_W'(OP_RTYPE):            nextState = EXECUTE;
          OP_W'(OP_BEQ):              nextState = BRANCH;
          OP_W'(OP_ADDI):             nextState = ADDIEXEC;
          OP_W'(OP_J):                nextState = JUMP;
          default: begin
            illegal   = 1'b1;
            nextState = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ulaSrcA    = 1'b1;
        ulaSrcB    = 2'b10;
        ulaControl = ULA_W'(ULA_ADD);
        nextState  = (bus.OP == OP_W'(OP_SW)) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        iorD = 1'b1;
        if (memReady) nextState = MEMWB;
      end
      MEMWB: begin
        memtoReg  = 1'b1;
        regWrite  = 1'b1;
        retireNow = 1'b1;
        nextState = FETCH;
      end
      MEMWRITE: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
        if (memReady) begin
          retireNow = 1'b1;
          nextState = FETCH;
        end
      end
      EXECUTE: begin
        ulaSrcA    = 1'b1;
        ulaControl = decUla;
        if (functValid) begin
          nextState = ALUWB;
        end else begin
          illegal   = 1'b1;
          nextState = FETCH;
        end
      end
      ALUWB: begin
        regDst     = 1'b1;
        regWrite   = 1'b1;
        ulaControl = heldUla;
        retireNow  = 1'b1;
        nextState  = FETCH;
      end
      BRANCH: begin
        ulaSrcA    = 1'b1;
        ulaControl = ULA_W'(ULA_SUB);
        branch     = 1'b1;
        pcSrc      = 2'b01;
        retireNow  = 1'b1;
        nextState  = FETCH;
      end
      ADDIEXEC: begin
        ulaSrcA    = 1'b1;
        ulaSrcB    = 2'b10;
        ulaControl = ULA_W'(ULA_ADD);
        nextState  = ADDIWB;
      end
      ADDIWB: begin
        regWrite  = 1'b1;
        retireNow = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        pcSrc     = 2'b10;
        pcWrite   = 1'b1;
        retireNow = 1'b1;
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  // Reset forces every control low combinationally, without waiting for clk.
  assign bus.IorD       = iorD & ~rst;
  assign bus.IRWrite    = irWrite & ~rst;
  assign bus.MemWrite   = memWrite & ~rst;
  assign bus.RegDst     = regDst & ~rst;
  assign bus.MemtoReg   = memtoReg & ~rst;
  assign bus.RegWrite   = regWrite & ~rst;
  assign bus.ULASrcA    = ulaSrcA & ~rst;
  assign bus.Branch     = branch & ~rst;
  assign bus.PCWrite    = pcWrite & ~rst;
  assign bus.Illegal    = illegal & ~rst;
  assign bus.ULASrcB    = rst ? 2'b00 : ulaSrcB;
  assign bus.PCSrc      = rst ? 2'b00 : pcSrc;
  assign bus.ULAControl = rst ? '0 : ulaControl;
  assign bus.Retired    = retired;
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// cycle-by-cycle control trace, and two DUTs (16-bit and 2-bit counters) are compared.
module tb_multicycle_control;
  import mips_pkg::*;

  typedef struct {
    state_t      st;
    logic [16:0] ctl;
    logic        mr;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;
  int   modelRetired = 0;
  cyc_t expQ[$];

  logic [5:0] opTab[6]    = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
  logic [5:0] functTab[5] = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};

  multicycle_control_if #(.OP_W(6), .ULA_W(3), .CNT_W(16)) bus ();
  multicycle_control_if #(.OP_W(6), .ULA_W(3), .CNT_W(2))  bus2 ();

  multicycle_control #(.OP_W(6), .ULA_W(3), .CNT_W(16), .USE_MEM_READY(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  multicycle_control #(.OP_W(6), .ULA_W(3), .CNT_W(2), .USE_MEM_READY(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.OP       = bus.OP;
  assign bus2.Funct    = bus.Funct;
  assign bus2.Zero     = bus.Zero;
  assign bus2.MemReady = bus.MemReady;

  always #5 clk = ~clk;

  logic [16:0] ctlObs, ctlObs2;
  assign ctlObs  = {bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                    bus.ULASrcA, bus.Branch, bus.PCWrite, bus.ULASrcB, bus.PCSrc, bus.ULAControl,
                    bus.Illegal};
  assign ctlObs2 = {bus2.IorD, bus2.IRWrite, bus2.MemWrite, bus2.RegDst, bus2.MemtoReg, bus2.RegWrite,
                    bus2.ULASrcA, bus2.Branch, bus2.PCWrite, bus2.ULASrcB, bus2.PCSrc, bus2.ULAControl,
                    bus2.Illegal};

  function automatic logic [16:0] mk(input logic iorD, input logic irWrite, input logic memWrite,
                                     input logic regDst, input logic memtoReg, input logic regWrite,
                                     input logic ulaSrcA, input logic branch, input logic pcWrite,
                                     input logic [1:0] ulaSrcB, input logic [1:0] pcSrc,
                                     input logic [2:0] ula, input logic illegal);
    return {iorD, irWrite, memWrite, regDst, memtoReg, regWrite, ulaSrcA, branch, pcWrite,
            ulaSrcB, pcSrc, ula, illegal};
  endfunction

  function automatic logic [2:0] ulaOf(input logic [5:0] fn, output bit ok);
    ok = 1'b1;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin
        ok = 1'b0;
        return 3'b000;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push(input state_t st, input logic [16:0] ctl, input logic mr);
    cyc_t c;
    c.st  = st;
    c.ctl = ctl;
    c.mr  = mr;
    expQ.push_back(c);
  endtask

  // Expected trace of one instruction, from fetch up to the return to FETCH.
  task automatic buildInstr(input logic [5:0] op, input logic [5:0] fn, input int fetchStall,
                            input int memStall, output bit legal);
    bit ok;
    logic [2:0] ula;
    expQ.delete();
    for (int i = 0; i < fetchStall; i++)
      push(FETCH, mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0), 1'b0);
    push(FETCH, mk(0,1,0,0,0,0,0,0,1,2'b01,2'b00,3'b010,0), 1'b1);
    legal = 1'b1;
    if (op == 6'b100011 || op == 6'b101011) begin
      push(DECODE, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), 1'($urandom_range(0,1)));
      push(MEMADR, mk(0,0,0,0,0,0,1,0,0,2'b10,2'b00,3'b010,0), 1'($urandom_range(0,1)));
      if (op == 6'b100011) begin
        for (int i = 0; i < memStall; i++)
          push(MEMREAD, mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 1'b0);
        push(MEMREAD, mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 1'b1);
        push(MEMWB, mk(0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b000,0), 1'($urandom_range(0,1)));
      end else begin
        for (int i = 0; i < memStall; i++)
          push(MEMWRITE, mk(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 1'b0);
        push(MEMWRITE, mk(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 1'b1);
      end
    end else if (op == 6'b000000) begin
      push(DECODE, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), 1'($urandom_range(0,1)));
      ula = ulaOf(fn, ok);
      if (ok) begin
        push(EXECUTE, mk(0,0,0,0,0,0,1,0,0,2'b00,2'b00,ula,0), 1'($urandom_range(0,1)));
        push(ALUWB, mk(0,0,0,1,0,1,0,0,0,2'b00,2'b00,ula,0), 1'($urandom_range(0,1)));
      end else begin
        push(EXECUTE, mk(0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b000,1), 1'($urandom_range(0,1)));
        legal = 1'b0;
      end
    end else if (op == 6'b000100) begin
      push(DECODE, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), 1'($urandom_range(0,1)));
      push(BRANCH, mk(0,0,0,0,0,0,1,1,0,2'b00,2'b01,3'b110,0), 1'($urandom_range(0,1)));
    end else if (op == 6'b001000) begin
      push(DECODE, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), 1'($urandom_range(0,1)));
      push(ADDIEXEC, mk(0,0,0,0,0,0,1,0,0,2'b10,2'b00,3'b010,0), 1'($urandom_range(0,1)));
      push(ADDIWB, mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0), 1'($urandom_range(0,1)));
    end else if (op == 6'b000010) begin
      push(DECODE, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), 1'($urandom_range(0,1)));
      push(JUMP, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,3'b000,0), 1'($urandom_range(0,1)));
    end else begin
      push(DECODE, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1), 1'($urandom_range(0,1)));
      legal = 1'b0;
    end
  endtask

  task automatic applyStimulus(input cyc_t c, input string name);
    bus.MemReady = c.mr;
    bus.Zero     = 1'($urandom_range(0,1));
    @(negedge clk);
    checkOutput({name, "/state"},  32'(bus.State),  32'(c.st));
    checkOutput({name, "/ctl"},    32'(ctlObs),     32'(c.ctl));
    checkOutput({name, "/state2"}, 32'(bus2.State), 32'(c.st));
    checkOutput({name, "/ctl2"},   32'(ctlObs2),    32'(c.ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fetchStall,
                          input int memStall, input string name);
    bit legal;
    bus.OP    = op;
    bus.Funct = fn;
    buildInstr(op, fn, fetchStall, memStall, legal);
    foreach (expQ[i]) applyStimulus(expQ[i], $sformatf("%s[%0d]", name, i));
    if (legal) modelRetired++;
    checkOutput({name, "/retired"},  32'(bus.Retired),  32'(modelRetired % 65536));
    checkOutput({name, "/retired2"}, 32'(bus2.Retired), 32'(modelRetired % 4));
    checkOutput({name, "/endstate"}, 32'(bus.State),    32'(FETCH));
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "/ctl"},      32'(ctlObs),       32'(0));
    checkOutput({name, "/ctl2"},     32'(ctlObs2),      32'(0));
    checkOutput({name, "/state"},    32'(bus.State),    32'(FETCH));
    checkOutput({name, "/retired"},  32'(bus.Retired),  32'(0));
    checkOutput({name, "/retired2"}, 32'(bus2.Retired), 32'(0));
  endtask

  initial begin
    logic [5:0] op, fn;
    bit         legal;

    rst          = 1'b1;
    bus.MemReady = 1'b1;
    bus.Zero     = 1'b0;
    bus.OP       = OP_SW;
    bus.Funct    = FUNCT_ADD;
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    modelRetired = 0;

    for (int i = 0; i < 5; i++)
      runInstr(OP_ADDI, 6'($urandom), 0, 0, $sformatf("addi%0d", i));

    runInstr(OP_RTYPE, FUNCT_ADD, 0, 0, "add");
    runInstr(OP_LW, 6'($urandom), 0, 3, "lw_stall3");
    runInstr(OP_SW, 6'($urandom), 0, 2, "sw_stall2");
    runInstr(6'b111111, FUNCT_ADD, 0, 0, "illegal_op");
    runInstr(OP_RTYPE, 6'b000111, 0, 0, "illegal_funct");
    runInstr(OP_BEQ, 6'($urandom), 0, 0, "beq");
    runInstr(OP_J, 6'($urandom), 0, 0, "j");
    runInstr(OP_RTYPE, FUNCT_SLT, 2, 0, "slt_fetchstall");

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
      end else begin
        op = opTab[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else                           fn = functTab[$urandom_range(0, 4)];
      runInstr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    // Reset while a store is stalled with MemWrite asserted.
    bus.OP    = OP_SW;
    bus.Funct = FUNCT_OR;
    buildInstr(OP_SW, FUNCT_OR, 0, 2, legal);
    for (int i = 0; i < 3; i++) applyStimulus(expQ[i], $sformatf("midrst[%0d]", i));
    bus.MemReady = 1'b0;
    @(negedge clk);
    checkOutput("midrst/memwrite", 32'(ctlObs), 32'(expQ[3].ctl));
    checkOutput("midrst/memwrite_state", 32'(bus.State), 32'(MEMWRITE));
    rst          = 1'b1;
    bus.MemReady = 1'b1;
    #1;
    checkResetState("midrst_async");
    @(posedge clk);
    #1;
    checkResetState("midrst_held");
    rst          = 1'b0;
    modelRetired = 0;

    runInstr(OP_RTYPE, FUNCT_SUB, 0, 0, "after_reset_sub");
    runInstr(OP_LW, FUNCT_ADD, 1, 1, "after_reset_lw");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
